// File: rtl/prog_mem_loader_pkg.sv
// Shared types and constants for the program-memory loader: FSM states,
// frame sync byte and the Fletcher-16 modular add.
package prog_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CK1,
        ST_CK2,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] SYNC_BYTE    = 8'hA5;
    localparam logic [8:0] FLETCHER_MOD = 9'd255;

    // (a + b) mod 255 with both operands already reduced: one conditional subtract suffices
    function automatic logic [7:0] mod255_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= FLETCHER_MOD) begin
            sum = sum - FLETCHER_MOD;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/prog_mem_loader_fletcher16_acc.sv
// Fletcher-16 running sums over a byte stream; clear restarts both sums at 0.
module fletcher16_acc
    import prog_mem_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] s1_o,
    output logic [7:0] s2_o
);

    logic [7:0] s1_q, s1_d;
    logic [7:0] s2_q, s2_d;

    // s2 accumulates the updated s1, not the previous one
    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (clear_i) begin
            s1_d = '0;
            s2_d = '0;
        end else if (en_i) begin
            s1_d = mod255_add(s1_q, byte_i);
            s2_d = mod255_add(s2_q, s1_d);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign s1_o = s1_q;
    assign s2_o = s2_q;

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction memory with a 1-cycle fetch port and a byte-stream loader that
// writes framed, Fletcher-16 protected images into the same RAM.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [WORD_W-1:0] fetch_data,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    output logic              loading,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned BYTES  = WORD_W / 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    words_q, words_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                loading_q, loading_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                ck1_ok_q, ck1_ok_d;
    logic [WORD_W-1:0]   fetch_data_q;

    logic                accept_c;
    logic                last_lane_c;
    logic                mem_we_c;
    logic                ck_clear_c;
    logic                ck_en_c;
    logic [15:0]         len16_c;
    logic [WORD_W-1:0]   wr_word_c;
    logic [7:0]          s1, s2;

    logic [WORD_W-1:0]   mem [DEPTH];

    assign rx_ready = ~reset;
    assign accept_c = rx_valid & rx_ready;

    fletcher16_acc u_ck (
        .clk     (clk),
        .reset   (reset),
        .clear_i (ck_clear_c),
        .en_i    (ck_en_c),
        .byte_i  (rx_byte),
        .s1_o    (s1),
        .s2_o    (s2)
    );

    // Frame parser: next-state and datapath updates
    always_comb begin
        state_d    = state_q;
        len_lo_d   = len_lo_q;
        len_d      = len_q;
        words_d    = words_q;
        addr_d     = addr_q;
        lane_d     = lane_q;
        word_d     = word_q;
        loading_d  = loading_q;
        done_d     = done_q;
        err_d      = err_q;
        ck1_ok_d   = ck1_ok_q;
        mem_we_c   = 1'b0;
        ck_clear_c = 1'b0;
        ck_en_c    = 1'b0;

        len16_c     = {rx_byte, len_lo_q};
        last_lane_c = (lane_q == LANE_W'(BYTES - 1));
        wr_word_c   = word_q;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (lane_q == LANE_W'(b)) begin
                wr_word_c[b*8 +: 8] = rx_byte;
            end
        end

        if (accept_c) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (rx_byte == SYNC_BYTE) begin
                        state_d    = ST_LEN_LO;
                        loading_d  = 1'b1;
                        done_d     = 1'b0;
                        err_d      = 1'b0;
                        words_d    = '0;
                        ck_clear_c = 1'b1;
                    end
                end
                ST_LEN_LO: begin
                    len_lo_d = rx_byte;
                    state_d  = ST_LEN_HI;
                end
                ST_LEN_HI: begin
                    if (17'(len16_c) > 17'(DEPTH)) begin
                        state_d   = ST_ERR;
                        loading_d = 1'b0;
                        err_d     = 1'b1;
                    end else if (len16_c == 16'd0) begin
                        state_d = ST_CK1;
                    end else begin
                        state_d = ST_DATA;
                        len_d   = CNT_W'(len16_c);
                        addr_d  = '0;
                        lane_d  = '0;
                    end
                end
                ST_DATA: begin
                    ck_en_c = 1'b1;
                    word_d  = wr_word_c;
                    if (last_lane_c) begin
                        mem_we_c = 1'b1;
                        addr_d   = addr_q + ADDR_W'(1);
                        words_d  = words_q + CNT_W'(1);
                        lane_d   = '0;
                        if (words_q + CNT_W'(1) == len_q) begin
                            state_d = ST_CK1;
                        end
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                    end
                end
                ST_CK1: begin
                    ck1_ok_d = (rx_byte == s1);
                    state_d  = ST_CK2;
                end
                ST_CK2: begin
                    loading_d = 1'b0;
                    if (ck1_ok_q && (rx_byte == s2)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_lo_q  <= '0;
            len_q     <= '0;
            words_q   <= '0;
            addr_q    <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ck1_ok_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_lo_q  <= len_lo_d;
            len_q     <= len_d;
            words_q   <= words_d;
            addr_q    <= addr_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ck1_ok_q  <= ck1_ok_d;
        end
    end

    // RAM contents survive reset; an aborted frame leaves written words in place
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[addr_q] <= wr_word_c;
        end
    end

    // Fetch port sees the pre-write word when the loader hits the same address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_data_q <= '0;
        end else begin
            fetch_data_q <= mem[fetch_addr];
        end
    end

    assign fetch_data   = fetch_data_q;
    assign loading      = loading_q;
    assign load_done    = done_q;
    assign load_err     = err_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: frame loads, checksum errors, length
// overflow, read-before-write on the fetch port and mid-frame reset.
module tb_prog_mem_loader;

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned ADDR_W4 = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [ADDR_W-1:0]   fetch_addr;
    logic [WORD_W-1:0]   fetch_data;
    logic                rx_valid;
    logic [7:0]          rx_byte;
    logic                rx_ready;
    logic                loading;
    logic                load_done;
    logic                load_err;
    logic [ADDR_W:0]     words_loaded;

    logic [ADDR_W4-1:0]  fetch_addr4;
    logic [WORD_W-1:0]   fetch_data4;
    logic                rx_valid4;
    logic                rx_ready4;
    logic                loading4;
    logic                load_done4;
    logic                load_err4;
    logic [ADDR_W4:0]    words_loaded4;

    int                  tests = 0;
    int                  fails = 0;
    logic [7:0]          tx_q[$];

    always #5 clk = ~clk;

    prog_mem_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_addr   (fetch_addr),
        .fetch_data   (fetch_data),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_ready     (rx_ready),
        .loading      (loading),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    prog_mem_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .fetch_addr   (fetch_addr4),
        .fetch_data   (fetch_data4),
        .rx_valid     (rx_valid4),
        .rx_byte      (rx_byte),
        .rx_ready     (rx_ready4),
        .loading      (loading4),
        .load_done    (load_done4),
        .load_err     (load_err4),
        .words_loaded (words_loaded4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Sends tx_q one byte per accepted cycle, with gap idle cycles before each byte
    task automatic send_q(input bit to4, input int gap);
        for (int i = 0; i < tx_q.size(); i++) begin
            repeat (gap) @(posedge clk);
            #1;
            rx_byte = tx_q[i];
            if (to4) rx_valid4 = 1'b1;
            else     rx_valid  = 1'b1;
            @(posedge clk);
            #1;
            rx_valid  = 1'b0;
            rx_valid4 = 1'b0;
        end
    endtask

    task automatic read_word(input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] exp, input string tag);
        fetch_addr = a;
        @(posedge clk);
        #1;
        check(tag, 32'(fetch_data), 32'(exp));
    endtask

    task automatic check_status(input string tag, input logic ld, input logic dn, input logic er,
                                input logic [ADDR_W:0] wl);
        check({tag, "_loading"}, 32'(loading), 32'(ld));
        check({tag, "_done"},    32'(load_done), 32'(dn));
        check({tag, "_err"},     32'(load_err), 32'(er));
        check({tag, "_words"},   32'(words_loaded), 32'(wl));
    endtask

    initial begin
        reset       = 1'b1;
        rx_valid    = 1'b0;
        rx_valid4   = 1'b0;
        rx_byte     = 8'h00;
        fetch_addr  = '0;
        fetch_addr4 = '0;

        #12;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_fetch_data", 32'(fetch_data), 32'd0);
        check_status("rst", 1'b0, 1'b0, 1'b0, 9'd0);

        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rx_ready_up", 32'(rx_ready), 32'd1);

        tx_q = '{8'h00, 8'hFF};
        send_q(1'b0, 0);
        check_status("junk", 1'b0, 1'b0, 1'b0, 9'd0);

        tx_q = '{8'hA5};
        send_q(1'b0, 0);
        check("sync_loading", 32'(loading), 32'd1);
        tx_q = '{8'h02, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'hCA, 8'hF5};
        send_q(1'b0, 2);
        check_status("good", 1'b0, 1'b1, 1'b0, 9'd2);
        read_word(8'd1, 16'h3433, "good_w1");
        read_word(8'd0, 16'h3231, "good_w0");

        fetch_addr = 8'd0;
        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hAB};
        send_q(1'b0, 0);
        rx_byte  = 8'hCD;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("rbw_old", 32'(fetch_data), 32'h3231);
        @(posedge clk);
        #1;
        check("rbw_new", 32'(fetch_data), 32'hCDAB);
        tx_q = '{8'h79, 8'h25};
        send_q(1'b0, 0);
        check_status("rbw_end", 1'b0, 1'b1, 1'b0, 9'd1);

        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'hCA, 8'hF4};
        send_q(1'b0, 1);
        check_status("bad_ck2", 1'b0, 1'b0, 1'b1, 9'd2);
        read_word(8'd0, 16'h3231, "bad_ck2_kept");

        tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h00, 8'h44};
        send_q(1'b0, 0);
        check_status("bad_ck1", 1'b0, 1'b0, 1'b1, 9'd1);
        read_word(8'd0, 16'h2211, "bad_ck1_kept");

        tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        send_q(1'b0, 3);
        check_status("zero_len", 1'b0, 1'b1, 1'b0, 9'd0);
        read_word(8'd0, 16'h2211, "zero_len_w0");
        read_word(8'd1, 16'h3433, "zero_len_w1");

        tx_q = '{8'hA5, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00};
        send_q(1'b0, 0);
        check_status("mod_wrap", 1'b0, 1'b1, 1'b0, 9'd1);
        read_word(8'd0, 16'hFFFF, "mod_wrap_w0");

        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03};
        send_q(1'b0, 0);
        check_status("mid_load", 1'b1, 1'b0, 1'b0, 9'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_status("mid_rst", 1'b0, 1'b0, 1'b0, 9'd0);
        read_word(8'd0, 16'h0201, "mid_rst_mem");

        tx_q = '{8'hA5, 8'h02, 8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'hCA, 8'hF5};
        send_q(1'b0, 0);
        check_status("fresh", 1'b0, 1'b1, 1'b0, 9'd2);
        read_word(8'd1, 16'h3433, "fresh_w1");
        read_word(8'd0, 16'h3231, "fresh_w0");

        tx_q = '{8'hA5, 8'h11, 8'h00};
        send_q(1'b1, 0);
        check("ovf_err", 32'(load_err4), 32'd1);
        check("ovf_loading", 32'(loading4), 32'd0);
        check("ovf_done", 32'(load_done4), 32'd0);
        check("ovf_words", 32'(words_loaded4), 32'd0);

        tx_q = '{8'hA5, 8'h10, 8'h00};
        send_q(1'b1, 0);
        check("full_len_loading", 32'(loading4), 32'd1);
        check("full_len_err", 32'(load_err4), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
